// File: rtl/mem_xfer_ctrl.sv
// Buffer load/save transfer engine between external memory and the on-chip buffer.
// Optional cycle counter output xfer_cycles is enabled by defining MEM_XFER_PERF_CNT_EN.
module mem_xfer_ctrl #(
    parameter int DW     = 16,
    parameter int BUF_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              start_save,
    input  logic              abort,
    input  logic [31:0]       load_mem_addr,
    input  logic [31:0]       load_words,
    input  logic [BUF_AW-1:0] load_buf_addr,
    input  logic [31:0]       save_mem_addr,
    input  logic [31:0]       save_words,
    input  logic [BUF_AW-1:0] save_buf_addr,
    output logic              busy,
    output logic              buffer_loaded,
    output logic              buffer_saved,
    output logic              mem_rd_req,
    output logic [31:0]       mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [DW-1:0]     mem_rd_data,
    output logic              mem_wr_req,
    output logic [31:0]       mem_wr_addr,
    output logic [DW-1:0]     mem_wr_data,
    input  logic              mem_wr_gnt,
    output logic              buf_wr_en,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic [DW-1:0]     buf_wr_data,
    output logic              buf_rd_en,
    output logic [BUF_AW-1:0] buf_rd_addr,
    input  logic [DW-1:0]     buf_rd_data
`ifdef MEM_XFER_PERF_CNT_EN
    ,
    output logic [31:0]       xfer_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_DATA,
        LD_WR,
        SV_RD,
        SV_CAP,
        SV_REQ,
        DONE
    } state_t;

    state_t            state;
    logic              is_load;
    logic [31:0]       mem_addr_q;
    logic [BUF_AW-1:0] buf_addr_q;
    logic [31:0]       remaining;

    // Outputs are registered and set on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            is_load       <= 1'b0;
            mem_addr_q    <= '0;
            buf_addr_q    <= '0;
            remaining     <= '0;
            busy          <= 1'b0;
            buffer_loaded <= 1'b0;
            buffer_saved  <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            mem_wr_req    <= 1'b0;
            mem_wr_addr   <= '0;
            mem_wr_data   <= '0;
            buf_wr_en     <= 1'b0;
            buf_wr_addr   <= '0;
            buf_wr_data   <= '0;
            buf_rd_en     <= 1'b0;
            buf_rd_addr   <= '0;
        end else begin
            buf_wr_en <= 1'b0;
            buf_rd_en <= 1'b0;
            if (abort && state != IDLE) begin
                // Abort beats a same-cycle grant: nothing advances and no flag is set.
                state      <= IDLE;
                busy       <= 1'b0;
                mem_rd_req <= 1'b0;
                mem_wr_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_load) begin
                            is_load       <= 1'b1;
                            buffer_loaded <= 1'b0;
                            busy          <= 1'b1;
                            mem_addr_q    <= load_mem_addr;
                            buf_addr_q    <= load_buf_addr;
                            remaining     <= load_words;
                            if (load_words == 32'd0) begin
                                state <= DONE;
                            end else begin
                                state       <= LD_REQ;
                                mem_rd_req  <= 1'b1;
                                mem_rd_addr <= load_mem_addr;
                            end
                        end else if (start_save) begin
                            is_load      <= 1'b0;
                            buffer_saved <= 1'b0;
                            busy         <= 1'b1;
                            mem_addr_q   <= save_mem_addr;
                            buf_addr_q   <= save_buf_addr;
                            remaining    <= save_words;
                            if (save_words == 32'd0) begin
                                state <= DONE;
                            end else begin
                                state       <= SV_RD;
                                buf_rd_en   <= 1'b1;
                                buf_rd_addr <= save_buf_addr;
                            end
                        end
                    end
                    LD_REQ: begin
                        if (mem_rd_gnt) begin
                            mem_rd_req <= 1'b0;
                            state      <= LD_DATA;
                        end
                    end
                    LD_DATA: begin
                        if (mem_rd_valid) begin
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= buf_addr_q;
                            buf_wr_data <= mem_rd_data;
                            state       <= LD_WR;
                        end
                    end
                    LD_WR: begin
                        mem_addr_q <= mem_addr_q + 32'd1;
                        buf_addr_q <= buf_addr_q + BUF_AW'(1);
                        remaining  <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            state <= DONE;
                        end else begin
                            state       <= LD_REQ;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= mem_addr_q + 32'd1;
                        end
                    end
                    SV_RD: begin
                        state <= SV_CAP;
                    end
                    SV_CAP: begin
                        mem_wr_req  <= 1'b1;
                        mem_wr_addr <= mem_addr_q;
                        mem_wr_data <= buf_rd_data;
                        state       <= SV_REQ;
                    end
                    SV_REQ: begin
                        if (mem_wr_gnt) begin
                            mem_wr_req <= 1'b0;
                            mem_addr_q <= mem_addr_q + 32'd1;
                            buf_addr_q <= buf_addr_q + BUF_AW'(1);
                            remaining  <= remaining - 32'd1;
                            if (remaining == 32'd1) begin
                                state <= DONE;
                            end else begin
                                state       <= SV_RD;
                                buf_rd_en   <= 1'b1;
                                buf_rd_addr <= buf_addr_q + BUF_AW'(1);
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (is_load) begin
                            buffer_loaded <= 1'b1;
                        end else begin
                            buffer_saved <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        mem_rd_req <= 1'b0;
                        mem_wr_req <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MEM_XFER_PERF_CNT_EN
    // Saturating busy-cycle counter, restarted by every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cycles <= '0;
        end else if (state == IDLE && (start_load || start_save)) begin
            xfer_cycles <= '0;
        end else if (busy && xfer_cycles != 32'hFFFF_FFFF) begin
            xfer_cycles <= xfer_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Directed self-checking bench for mem_xfer_ctrl: a per-cycle vector table for the
// main load/save/zero-length runs, then hand-written abort, hold and reset sequences.
module tb_mem_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load, start_save, abort;
    logic [31:0] load_mem_addr, load_words, save_mem_addr, save_words;
    logic [15:0] load_buf_addr, save_buf_addr;
    logic        busy, buffer_loaded, buffer_saved;
    logic        mem_rd_req, mem_rd_gnt, mem_rd_valid;
    logic [31:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        mem_wr_req, mem_wr_gnt;
    logic [31:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic        buf_wr_en, buf_rd_en;
    logic [15:0] buf_wr_addr, buf_wr_data, buf_rd_addr;
    logic [15:0] buf_rd_data = '0;
`ifdef MEM_XFER_PERF_CNT_EN
    logic [31:0] xfer_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    mem_xfer_ctrl #(.DW(16), .BUF_AW(16)) dut (
        .clk(clk), .rst(rst),
        .start_load(start_load), .start_save(start_save), .abort(abort),
        .load_mem_addr(load_mem_addr), .load_words(load_words), .load_buf_addr(load_buf_addr),
        .save_mem_addr(save_mem_addr), .save_words(save_words), .save_buf_addr(save_buf_addr),
        .busy(busy), .buffer_loaded(buffer_loaded), .buffer_saved(buffer_saved),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_gnt(mem_wr_gnt),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data)
`ifdef MEM_XFER_PERF_CNT_EN
        , .xfer_cycles(xfer_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start_load, start_save, abort, rd_gnt, rd_valid, wr_gnt;
        logic [31:0] ld_words;
        logic [15:0] rd_data;
        logic        busy, loaded, saved, rd_req, wr_req, bwr_en, brd_en;
        logic [31:0] rd_addr, wr_addr;
        logic [15:0] wr_data, bwr_addr, bwr_data, brd_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[15:0] ^ 16'h5A00;
    endfunction

    function automatic logic [15:0] buf_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h0F0F;
    endfunction

    // Buffer model: read data appears exactly one cycle after the read strobe.
    always @(posedge clk) buf_rd_data <= buf_rd_en ? buf_word(buf_rd_addr) : 16'h0000;

    function automatic vec_t blank();
        return '0;
    endfunction

    function automatic logic [159:0] pack_exp(input vec_t v);
        return {25'h0, v.busy, v.loaded, v.saved, v.rd_req, v.wr_req, v.bwr_en, v.brd_en,
                v.rd_req ? v.rd_addr : 32'h0,
                v.wr_req ? {v.wr_addr, v.wr_data} : 48'h0,
                v.bwr_en ? {v.bwr_addr, v.bwr_data} : 32'h0,
                v.brd_en ? v.brd_addr : 16'h0};
    endfunction

    function automatic logic [159:0] pack_act(input vec_t v);
        return {25'h0, busy, buffer_loaded, buffer_saved, mem_rd_req, mem_wr_req, buf_wr_en, buf_rd_en,
                v.rd_req ? mem_rd_addr : 32'h0,
                v.wr_req ? {mem_wr_addr, mem_wr_data} : 48'h0,
                v.bwr_en ? {buf_wr_addr, buf_wr_data} : 32'h0,
                v.brd_en ? buf_rd_addr : 16'h0};
    endfunction

    function automatic logic [159:0] all_outputs();
        return 160'({busy, buffer_loaded, buffer_saved, mem_rd_req, mem_rd_addr, mem_wr_req,
                     mem_wr_addr, mem_wr_data, buf_wr_en, buf_wr_addr, buf_wr_data,
                     buf_rd_en, buf_rd_addr});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start_load   = v.start_load;
        start_save   = v.start_save;
        abort        = v.abort;
        mem_rd_gnt   = v.rd_gnt;
        mem_rd_valid = v.rd_valid;
        mem_wr_gnt   = v.wr_gnt;
        load_words   = v.ld_words;
        mem_rd_data  = v.rd_data;
        tick();
    endtask

    task automatic clear_inputs();
        start_load   = 1'b0;
        start_save   = 1'b0;
        abort        = 1'b0;
        mem_rd_gnt   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_wr_gnt   = 1'b0;
        mem_rd_data  = 16'h0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        v;
        logic [15:0] ba;
        logic [31:0] ma;

        // Load of 4 words from 0x1000 into buffer 0x0010, immediate grant/valid.
        v = blank(); v.start_load = 1; v.ld_words = 32'd4;
        v.busy = 1; v.rd_req = 1; v.rd_addr = 32'h1000;
        vecs.push_back(v);
        for (int w = 0; w < 4; w++) begin
            v = blank(); v.rd_gnt = 1; v.busy = 1;
            vecs.push_back(v);
            v = blank(); v.rd_valid = 1; v.rd_data = mem_word(32'h1000 + 32'(w)); v.busy = 1;
            v.bwr_en = 1; v.bwr_addr = 16'h0010 + 16'(w); v.bwr_data = mem_word(32'h1000 + 32'(w));
            vecs.push_back(v);
            v = blank(); v.busy = 1;
            if (w < 3) begin
                v.rd_req = 1; v.rd_addr = 32'h1000 + 32'(w) + 32'd1;
            end
            vecs.push_back(v);
        end
        v = blank(); v.loaded = 1;
        vecs.push_back(v);

        // Save of 3 words crossing both the buffer and memory address wrap.
        v = blank(); v.start_save = 1; v.busy = 1; v.loaded = 1;
        v.brd_en = 1; v.brd_addr = 16'hFFFE;
        vecs.push_back(v);
        for (int w = 0; w < 3; w++) begin
            ba = 16'hFFFE + 16'(w);
            ma = 32'hFFFF_FFFF + 32'(w);
            v = blank(); v.busy = 1; v.loaded = 1;
            vecs.push_back(v);
            v = blank(); v.busy = 1; v.loaded = 1;
            v.wr_req = 1; v.wr_addr = ma; v.wr_data = buf_word(ba);
            vecs.push_back(v);
            v = blank(); v.wr_gnt = 1; v.busy = 1; v.loaded = 1;
            if (w < 2) begin
                v.brd_en = 1; v.brd_addr = ba + 16'd1;
            end
            vecs.push_back(v);
        end
        v = blank(); v.loaded = 1; v.saved = 1;
        vecs.push_back(v);

        // Zero-length load: one DONE cycle, then the flag.
        v = blank(); v.start_load = 1; v.ld_words = 32'd0; v.busy = 1; v.saved = 1;
        vecs.push_back(v);
        v = blank(); v.loaded = 1; v.saved = 1;
        vecs.push_back(v);

        clear_inputs();
        rst = 1'b1;
        load_mem_addr = 32'h0000_1000; load_words = 32'd4; load_buf_addr = 16'h0010;
        save_mem_addr = 32'hFFFF_FFFF; save_words = 32'd3; save_buf_addr = 16'hFFFE;
        tick();
        tick();
        checkOutput("reset_state", all_outputs(), 160'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), pack_act(vecs[i]), pack_exp(vecs[i]));
        end
        clear_inputs();

        // Reset with non-zero flags and addresses clears everything.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("reset_after_run", all_outputs(), 160'h0);

        // Simultaneous starts: load wins, later save while busy is ignored.
        load_words = 32'd1;
        start_load = 1'b1; start_save = 1'b1;
        tick();
        start_load = 1'b0; start_save = 1'b0;
        checkOutput("dual_start", 160'({busy, mem_rd_req, buf_rd_en, mem_rd_addr}), 160'({1'b1, 1'b1, 1'b0, 32'h1000}));
        start_save = 1'b1;
        tick();
        start_save = 1'b0;
        checkOutput("save_while_busy", 160'({busy, mem_rd_req, buf_rd_en, buffer_saved}), 160'({1'b1, 1'b1, 1'b0, 1'b0}));
        mem_rd_gnt = 1'b1;
        tick();
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = mem_word(32'h1000);
        tick();
        mem_rd_valid = 1'b0;
        checkOutput("dual_buf_wr", 160'({buf_wr_en, buf_wr_addr, buf_wr_data}), 160'({1'b1, 16'h0010, mem_word(32'h1000)}));
        tick();
        tick();
        tick();
        checkOutput("dual_done", 160'({busy, buffer_loaded, buffer_saved, mem_wr_req, buf_rd_en}), 160'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));

        // Abort during the data wait of word 2 of 5, then a late read return.
        load_words = 32'd5;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        mem_rd_gnt = 1'b1;
        tick();
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = mem_word(32'h1000);
        tick();
        mem_rd_valid = 1'b0;
        tick();
        checkOutput("abort_pre", 160'({busy, mem_rd_req, mem_rd_addr, buffer_loaded}), 160'({1'b1, 1'b1, 32'h1001, 1'b0}));
        mem_rd_gnt = 1'b1;
        tick();
        mem_rd_gnt = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort", 160'({busy, mem_rd_req, buf_wr_en, buffer_loaded}), 160'h0);
        mem_rd_valid = 1'b1; mem_rd_data = mem_word(32'h1001);
        tick();
        mem_rd_valid = 1'b0;
        checkOutput("late_valid", 160'({busy, buf_wr_en, buffer_loaded}), 160'h0);
        tick();
        checkOutput("late_valid_idle", 160'({busy, buf_wr_en, mem_rd_req}), 160'h0);

        // Write grant withheld for 7 cycles: request, address and data hold.
        save_words = 32'd2;
        start_save = 1'b1;
        tick();
        start_save = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("wr_hold%0d", i), 160'({mem_wr_req, mem_wr_addr, mem_wr_data}),
                        160'({1'b1, 32'hFFFF_FFFF, buf_word(16'hFFFE)}));
            tick();
        end
        mem_wr_gnt = 1'b1;
        tick();
        mem_wr_gnt = 1'b0;
        checkOutput("after_gnt", 160'({mem_wr_req, buf_rd_en, buf_rd_addr}), 160'({1'b0, 1'b1, 16'hFFFF}));
        tick();
        tick();
        checkOutput("wr_word2", 160'({mem_wr_req, mem_wr_addr, mem_wr_data}), 160'({1'b1, 32'h0, buf_word(16'hFFFF)}));

        // Grant and abort together on the last word: abort wins, no completion.
        mem_wr_gnt = 1'b1; abort = 1'b1;
        tick();
        mem_wr_gnt = 1'b0; abort = 1'b0;
        checkOutput("gnt_abort", 160'({busy, mem_wr_req, buffer_saved, buf_rd_en}), 160'h0);
        tick();
        checkOutput("gnt_abort_idle", 160'({busy, buffer_saved}), 160'h0);

        // Reset in the middle of a save.
        start_save = 1'b1;
        tick();
        start_save = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_mid", all_outputs(), 160'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
